// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the fetch -> queue -> decode path.
//   OPCODE_W, OPERAND_W : default instruction field widths
//   insn_t              : one instruction as carried between pipeline stages
package cpu_pkg;

   localparam int OPCODE_W  = 16;
   localparam int OPERAND_W = 32;

   typedef struct packed {
      logic [OPCODE_W-1:0]  opcode;
      logic [OPERAND_W-1:0] operand;
   } insn_t;

endpackage

// File: rtl/cpu_insn_queue.sv
// cpu_insn_queue
// DEPTH-entry circular instruction buffer between fetch and decode.
// Ports:
//   clk_i, rst_i (async, active-low)      clock and reset
//   flush_i                               synchronous discard of all entries
//   valid_i, ready_o, opcode_i, operand_i fetch-side push interface
//   valid_o, ready_i, opcode_o, operand_o decode-side pop interface (head, FWFT)
//   count_o                               occupied entries, 0..DEPTH
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on that side (push = valid_i & ready_o, pop = valid_o & ready_i).
// ready_o and valid_o depend on registered state only, never on valid_i or
// ready_i, so a full queue refuses a push even if decode pops in that cycle.
module cpu_insn_queue #(
   parameter int OPCODE_W  = cpu_pkg::OPCODE_W,
   parameter int OPERAND_W = cpu_pkg::OPERAND_W,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [OPCODE_W-1:0]  opcode_i,
   input  logic [OPERAND_W-1:0] operand_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [OPCODE_W-1:0]  opcode_o,
   output logic [OPERAND_W-1:0] operand_o,
   output logic [CNT_W-1:0]     count_o
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = OPCODE_W + OPERAND_W;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wp;
   logic [PTR_W-1:0]   rp;
   logic [CNT_W-1:0]   cnt;
   logic               push;
   logic               pop;

   assign ready_o = (cnt != CNT_W'(DEPTH));
   assign valid_o = (cnt != '0);
   assign count_o = cnt;
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;

   // First-word fall-through: the head entry is always on the outputs.
   assign {opcode_o, operand_o} = mem[rp];

   // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush_i) begin
         // Storage is left alone; only the bookkeeping is cleared.
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) begin
            mem[wp] <= {opcode_i, operand_i};
            wp      <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_insn_queue.sv
// tb_cpu_insn_queue
// Directed bench for cpu_insn_queue (DEPTH = 4). Inputs are driven 1 time
// unit after a rising edge and outputs are checked at that same point, so
// every check sees the state left by the preceding edge.
module tb_cpu_insn_queue;

   localparam int OPCODE_W  = 16;
   localparam int OPERAND_W = 32;
   localparam int DEPTH     = 4;
   localparam int CNT_W     = 3;
   localparam int W         = OPCODE_W + OPERAND_W;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b0;
   logic                 flush_i = 1'b0;
   logic                 valid_i = 1'b0;
   logic                 ready_o;
   logic [OPCODE_W-1:0]  opcode_i = '0;
   logic [OPERAND_W-1:0] operand_i = '0;
   logic                 valid_o;
   logic                 ready_i = 1'b0;
   logic [OPCODE_W-1:0]  opcode_o;
   logic [OPERAND_W-1:0] operand_o;
   logic [CNT_W-1:0]     count_o;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   cpu_insn_queue #(
      .OPCODE_W (OPCODE_W),
      .OPERAND_W(OPERAND_W),
      .DEPTH    (DEPTH)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .flush_i  (flush_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .opcode_i (opcode_i),
      .operand_i(operand_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .opcode_o (opcode_o),
      .operand_o(operand_o),
      .count_o  (count_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear();
      valid_i = 1'b0;
      ready_i = 1'b0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
   endtask

   task automatic test_reset();
      // Reset asserted from time 0
      #2;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
      checks++; if ({opcode_o, operand_o} !== 48'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {opcode_o, operand_o}); end
      rst_i = 1'b1;
      tick();
      // Queue 3 entries, then assert reset mid-stream between edges
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valid_i = 1'b1; opcode_i = 16'(i + 7); operand_i = 32'(i);
         tick();
      end
      valid_i = 1'b0;
      checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL pre_reset_count got=%0d exp=3", count_o); end
      rst_i = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", valid_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", ready_o); end
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL midreset_count got=%0d exp=0", count_o); end
      checks++; if (opcode_o !== 16'h0) begin errors++; $display("FAIL midreset_opcode got=%h exp=0", opcode_o); end
      #2;
      rst_i = 1'b1;
      // Push on the first edge after release
      valid_i = 1'b1; opcode_i = 16'h1234; operand_i = 32'hDEADBEEF;
      tick();
      valid_i = 1'b0;
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL post_reset_valid got=%b exp=1", valid_o); end
      checks++; if (opcode_o !== 16'h1234) begin errors++; $display("FAIL post_reset_opcode got=%h exp=1234", opcode_o); end
      checks++; if (operand_o !== 32'hDEADBEEF) begin errors++; $display("FAIL post_reset_operand got=%h exp=deadbeef", operand_o); end
      checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL post_reset_count got=%0d exp=1", count_o); end
   endtask

   task automatic test_no_bypass();
      clear();
      valid_i = 1'b1; opcode_i = 16'h0055; operand_i = 32'h5;
      #1;
      // Before the edge the entry must not be visible yet
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bypass_valid got=%b exp=0", valid_o); end
      tick();
      valid_i = 1'b0;
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1", valid_o); end
   endtask

   task automatic test_fill_backpressure();
      clear();
      ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         valid_i = 1'b1; opcode_i = 16'(i); operand_i = 32'(i * 16);
         checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%b exp=1", i, ready_o); end
         tick();
      end
      // 5th instruction presented and held while full
      opcode_i = 16'd5; operand_i = 32'd80;
      for (int k = 0; k < 2; k++) begin
         checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", ready_o); end
         checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count_o); end
         tick();
      end
      checks++; if (opcode_o !== 16'd1) begin errors++; $display("FAIL full_head got=%0d exp=1", opcode_o); end
      // Full with push and pop requested: only the pop happens
      ready_i = 1'b1;
      tick();
      checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL full_pop_count got=%0d exp=3", count_o); end
      checks++; if (opcode_o !== 16'd2) begin errors++; $display("FAIL full_pop_head got=%0d exp=2", opcode_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_ready got=%b exp=1", ready_o); end
      // Now the 5th is accepted alongside a pop
      tick();
      valid_i = 1'b0;
      checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL accept5_count got=%0d exp=3", count_o); end
      for (int i = 3; i <= 5; i++) begin
         checks++; if (opcode_o !== 16'(i)) begin errors++; $display("FAIL drain_opcode got=%0d exp=%0d", opcode_o, i); end
         checks++; if (operand_o !== 32'(i * 16)) begin errors++; $display("FAIL drain_operand got=%0d exp=%0d", operand_o, i * 16); end
         tick();
      end
      ready_i = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL drained_valid got=%b exp=0", valid_o); end
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL drained_count got=%0d exp=0", count_o); end
   endtask

   task automatic test_back_to_back();
      clear();
      ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         valid_i = 1'b1; opcode_i = 16'(i); operand_i = 32'(i * 3 + 1);
         tick();
         checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid_%0d got=%b exp=1", i, valid_o); end
         checks++; if (opcode_o !== 16'(i)) begin errors++; $display("FAIL stream_opcode got=%0d exp=%0d", opcode_o, i); end
         checks++; if (operand_o !== 32'(i * 3 + 1)) begin errors++; $display("FAIL stream_operand got=%0d exp=%0d", operand_o, i * 3 + 1); end
         checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL stream_count got=%0d exp=1", count_o); end
      end
      valid_i = 1'b0;
      tick();
      ready_i = 1'b0;
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL stream_end_count got=%0d exp=0", count_o); end
   endtask

   task automatic test_flush();
      clear();
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valid_i = 1'b1; opcode_i = 16'(16 + i); operand_i = 32'(i);
         tick();
      end
      checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL preflush_count got=%0d exp=3", count_o); end
      flush_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; opcode_i = 16'h0013;
      tick();
      flush_i = 1'b0; ready_i = 1'b0;
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
      opcode_i = 16'h00AA; operand_i = 32'h0000_00AA;
      tick();
      valid_i = 1'b0;
      checks++; if (opcode_o !== 16'h00AA) begin errors++; $display("FAIL postflush_head got=%h exp=00aa", opcode_o); end
      checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL postflush_count got=%0d exp=1", count_o); end
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL postflush_stale got=%b exp=0", valid_o); end
   endtask

   task automatic test_random();
      int cyc_errs;
      logic exp_push, exp_pop;
      logic [W-1:0] head;
      cyc_errs = 0;
      clear();
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         valid_i   = ($urandom_range(0, 99) < 60);
         ready_i   = ($urandom_range(0, 99) < 50);
         flush_i   = ($urandom_range(0, 99) < 3);
         opcode_i  = 16'($urandom_range(0, 65535));
         operand_i = $urandom;
         #1;
         checks++; if (count_o !== CNT_W'(exp_q.size())) begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, count_o, exp_q.size()); end
         checks++; if (valid_o !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, valid_o, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            head = exp_q[0];
            checks++; if ({opcode_o, operand_o} !== head) begin errors++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", c, {opcode_o, operand_o}, head); end
         end
         exp_push = valid_i && (exp_q.size() != DEPTH);
         exp_pop  = ready_i && (exp_q.size() != 0);
         if (flush_i) begin
            exp_q.delete();
         end else begin
            if (exp_pop) void'(exp_q.pop_front());
            if (exp_push) exp_q.push_back({opcode_i, operand_i});
         end
         tick();
      end
      valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_no_bypass();
      test_fill_backpressure();
      test_back_to_back();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
